// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM with combinational
// immediate-format and ALU-operation decode.
// Optional feature: define MC_BNE_EN to let the BEQ state also resolve bne
// (funct3[0] inverts the branch condition).
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, ALUWB, EXECI, JAL, BEQ
    } state_t;

    state_t     state, next_state;
    logic       pcupdate, branch, taken;
    logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;
    logic [1:0] aluop;

    // State register, forced to FETCH asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Next-state and per-state control decode
    always_comb begin
        next_state = FETCH;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        AdrSrc     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                irwrite_s  = MemReady;
                pcupdate   = MemReady;
                next_state = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011,
                    7'b0100011: next_state = MEMADR;
                    7'b0110011: next_state = EXECR;
                    7'b0010011: next_state = EXECI;
                    7'b1101111: next_state = JAL;
                    7'b1100011: next_state = BEQ;
                    default: begin
                        next_state = FETCH;
                        illegal_s  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_s = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                next_state = MemReady ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                aluop      = 2'b10;
                next_state = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                aluop      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                regwrite_s = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcupdate   = 1'b1;
                next_state = ALUWB;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                aluop      = 2'b01;
                branch     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Immediate format selected directly from the opcode
    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    // ALU operation from ALUOp class and funct fields
    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

`ifdef MC_BNE_EN
    assign taken = Zero ^ funct3[0];
`else
    assign taken = Zero;
`endif

    // FETCH is the reset state but its MemReady-driven strobes must stay
    // quiet while reset is held, so every write-type output is gated here.
    assign PCWrite  = ~reset & (pcupdate | (branch & taken));
    assign IRWrite  = ~reset & irwrite_s;
    assign MemWrite = ~reset & memwrite_s;
    assign RegWrite = ~reset & regwrite_s;
    assign Illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller; expectations are hand-derived
// per state. Honors MC_BNE_EN for the bne branch case.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    int checks   = 0;
    int failures = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl,Illegal}
    function automatic logic [16:0] ev(input logic pcw, adr, irw, mw, rw,
                                       input logic [1:0] a, b, rs, imm,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, adr, irw, mw, rw, a, b, rs, imm, alu, ill};
    endfunction

    task automatic chk(input string tag, input logic [16:0] e);
        logic [16:0] obs;
        obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, ALUControl, Illegal};
        checks++;
        assert (obs === e) else begin
            failures++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, e);
            $error("check %s mismatched", tag);
        end
    endtask

    // Apply cycle inputs, check outputs mid-cycle, then advance one clock
    task automatic cyc(input logic mr, input logic z, input string tag, input logic [16:0] e);
        MemReady = mr;
        Zero     = z;
        #1;
        chk(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic setinst(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
        setinst(7'b0000011, 3'b010, 1'b0);
        #2;
        chk("reset_async", ev(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        @(posedge clk); #1;
        chk("reset_held_edge", ev(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        reset = 1'b0;

        // lw, one wait cycle in FETCH, then MemReady=1 throughout
        cyc(0,0, "lw_fetch_wait", ev(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "lw_fetch",      ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "lw_decode",     ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "lw_memadr",     ev(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "lw_memread",    ev(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "lw_memwb",      ev(0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0));

        // sw with three MemReady=0 cycles in MEMWRITE
        setinst(7'b0100011, 3'b010, 1'b0);
        cyc(1,0, "sw_fetch",      ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b01, 3'b000, 0));
        cyc(1,0, "sw_decode",     ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b01, 3'b000, 0));
        cyc(1,0, "sw_memadr",     ev(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0));
        for (int i = 0; i < 3; i++)
            cyc(0,0, "sw_memwrite_wait", ev(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0));
        cyc(1,0, "sw_memwrite_done", ev(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0));

        // R-type sub
        setinst(7'b0110011, 3'b000, 1'b1);
        cyc(1,0, "sub_fetch",     ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "sub_decode",    ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "sub_execr",     ev(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0));
        cyc(1,0, "sub_aluwb",     ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));

        // R-type slt, or, and: checks at EXECR
        setinst(7'b0110011, 3'b010, 1'b0);
        cyc(1,0, "slt_fetch",     ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "slt_decode",    ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "slt_execr",     ev(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b101, 0));
        cyc(1,0, "slt_aluwb",     ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        setinst(7'b0110011, 3'b110, 1'b0);
        cyc(1,0, "or_fetch",      ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "or_decode",     ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "or_execr",      ev(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b011, 0));
        cyc(1,0, "or_aluwb",      ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        setinst(7'b0110011, 3'b111, 1'b0);
        cyc(1,0, "and_fetch",     ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "and_decode",    ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "and_execr",     ev(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b010, 0));
        cyc(1,0, "and_aluwb",     ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));

        // I-type addi with funct7b5=1: op[5]=0 so still add
        setinst(7'b0010011, 3'b000, 1'b1);
        cyc(1,0, "addi_fetch",    ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "addi_decode",   ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "addi_execi",    ev(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "addi_aluwb",    ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));

        // jal
        setinst(7'b1101111, 3'b000, 1'b0);
        cyc(1,0, "jal_fetch",     ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b11, 3'b000, 0));
        cyc(1,0, "jal_decode",    ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b11, 3'b000, 0));
        cyc(1,0, "jal_jal",       ev(1,0,0,0,0, 2'b01,2'b10,2'b00,2'b11, 3'b000, 0));
        cyc(1,0, "jal_aluwb",     ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 3'b000, 0));

        // beq taken, then beq not taken
        setinst(7'b1100011, 3'b000, 1'b0);
        cyc(1,0, "beq_t_fetch",   ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b10, 3'b000, 0));
        cyc(1,0, "beq_t_decode",  ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0));
        cyc(1,1, "beq_taken",     ev(1,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b001, 0));
        cyc(1,0, "beq_n_fetch",   ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b10, 3'b000, 0));
        cyc(1,0, "beq_n_decode",  ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0));
        cyc(1,0, "beq_not_taken", ev(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b001, 0));

        // bne encoding (funct3=001) with Zero=0
        setinst(7'b1100011, 3'b001, 1'b0);
        cyc(1,0, "bne_fetch",     ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b10, 3'b000, 0));
        cyc(1,0, "bne_decode",    ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0));
`ifdef MC_BNE_EN
        cyc(1,0, "bne_zero0",     ev(1,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b001, 0));
`else
        cyc(1,0, "bne_zero0",     ev(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b001, 0));
`endif

        // illegal opcode: Illegal only in DECODE, then FETCH
        setinst(7'b1111111, 3'b000, 1'b0);
        cyc(1,0, "ill_fetch",     ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "ill_decode",    ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 1));
        cyc(0,0, "ill_back_fetch",ev(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));

        // reset asserted mid-MEMREAD
        setinst(7'b0000011, 3'b010, 1'b0);
        cyc(1,0, "rst_lw_fetch",  ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "rst_lw_decode", ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));
        cyc(1,0, "rst_lw_memadr", ev(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0));
        MemReady = 1'b0;
        #1;
        chk("rst_lw_memread", ev(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        reset = 1'b1;
        MemReady = 1'b1;
        #1;
        chk("rst_mid_memread", ev(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        @(posedge clk); #1;
        chk("rst_mid_held",    ev(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        reset = 1'b0;
        cyc(1,0, "rst_release_fetch", ev(1,0,1,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0));
        cyc(1,0, "rst_release_decode",ev(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 3'b000, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, async active-high.
REQ-002 SHALL have inputs: op 7 (instr[6:0]); funct3 3 (instr[14:12]); funct7b5 1 (instr[30]); Zero 1 (ALU zero flag); MemReady 1 (memory access completes this cycle).
REQ-003 SHALL have outputs: PCWrite 1; AdrSrc 1 (0=PC, 1=Result); IRWrite 1; MemWrite 1; RegWrite 1; ALUSrcA 2 (00=PC, 01=OldPC, 10=RegA); ALUSrcB 2 (00=RegB, 01=ImmExt, 10=const 4); ResultSrc 2 (00=ALUOut, 01=ReadData, 10=ALUResult); ImmSrc 2 (00=I, 01=S, 10=B, 11=J); ALUControl 3 (000 add, 001 sub, 010 and, 011 or, 101 slt); Illegal 1.

Function
REQ-004 SHALL be a Moore FSM; states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ.
REQ-005 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00; IRWrite and PCUpdate only while MemReady=1; stay until MemReady=1, then DECODE.
REQ-006 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH with Illegal=1 for that cycle.
REQ-007 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op=0000011 -> MEMREAD, else MEMWRITE.
REQ-008 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then MEMWB.
REQ-009 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-010 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle in state; hold until MemReady=1, then FETCH.
REQ-011 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> ALUWB.
REQ-012 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-013 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB.
REQ-014 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-015 Any control not listed for a state SHALL be 0; unreachable state encodings SHALL go to FETCH.
REQ-016 PCWrite SHALL be combinational: PCUpdate | (Branch & Zero), Zero sampled same cycle.
REQ-017 ImmSrc SHALL decode from op combinationally: 0000011/0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; other -> 00.
REQ-018 ALUControl: ALUOp=00 -> 000; 01 -> 001; 10 by funct3: 000 -> 001 if (funct7b5 & op[5]) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
REQ-019 Instruction latency with MemReady=1: lw 5 cycles; sw 4; R/I-type 4; jal 4; beq 3; illegal 2. Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.

Reset
REQ-020 reset=1 SHALL force state to FETCH asynchronously, including mid-instruction; all registered state cleared.
REQ-021 During reset all write-type outputs (PCWrite, IRWrite, MemWrite, RegWrite) and Illegal SHALL be 0; other outputs take FETCH values.
REQ-022 First FETCH evaluation SHALL occur on first rising clk after reset deasserts.

Configuration
REQ-023 Macro MC_BNE_EN defined: BEQ state SHALL also serve bne; PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])); funct3=001 branches when Zero=0.
REQ-024 MC_BNE_EN undefined: PCWrite = PCUpdate | (Branch & Zero) regardless of funct3.

Verification
REQ-025 lw (op=0000011), MemReady=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-026 sw with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-027 beq Zero=1 -> PCWrite=1 in BEQ cycle; Zero=0 -> PCWrite=0; then FETCH.
REQ-028 R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; slt (funct3=010) -> 101.
REQ-029 op=1111111 -> Illegal=1 in DECODE, no writes, FETCH next cycle.
REQ-030 reset asserted mid-MEMREAD -> immediate FETCH, write enables 0; with MC_BNE_EN, funct3=001, Zero=0 -> PCWrite=1.
